vigenere_stream_decryptor: RTL and testbench

//   Streaming Vigenere decryptor, the receive-side counterpart of vigenere_encryptor.
//   - Holds a loadable key of up to MAX_KEY_LEN ASCII 'A'-'Z' characters.
//   - Decrypts a ready/valid ciphertext byte stream one character per cycle, with one registered output stage.
//   - Advances the key position per decrypted letter, wrapping at key length.

---
 rtl/vigenere_stream_decryptor.sv | 186 ++++++++++++++++++
 tb/tb_vigenere_stream_decryptor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vigenere_stream_decryptor.sv
// Streaming Vigenere decryptor: loadable A-Z key, ready/valid ciphertext in,
// one registered plaintext stage out. Non-letters pass through without using a key slot.
module vigenere_stream_decryptor #(
    parameter int MAX_KEY_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_valid,
    input  logic [7:0] key_char,
    input  logic       key_last,
    output logic       key_ready,
    output logic       key_loaded,
    output logic       key_err,
    input  logic       resync,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char
);
    localparam int KW = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;
    localparam int LW = KW + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_KEY_LEN);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] key_len_q, key_len_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [7:0]    key_mem_q [MAX_KEY_LEN];
    logic [7:0]    key_mem_d [MAX_KEY_LEN];
    logic          key_err_q, key_err_d;
    logic          key_ready_q, key_ready_d;
    logic          key_loaded_q, key_loaded_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_char_q, out_char_d;

    logic          key_legal_s;
    logic          in_letter_s;
    logic          accept_s;
    logic          kidx_wrap_s;
    logic [LW-1:0] key_len_inc_s;
    logic [LW-1:0] key_len_new_s;
    logic [7:0]    k_off_s;
    logic [7:0]    c_off_s;
    logic [7:0]    plain_s;

    // Back-pressure: a stalled output blocks new input only until it drains this cycle.
    assign in_ready = (state_q == ST_RUN) & ~key_start & ~resync & (~out_valid_q | out_ready);
    assign accept_s = in_valid & in_ready;

    assign key_ready  = key_ready_q;
    assign key_loaded = key_loaded_q;
    assign key_err    = key_err_q;
    assign out_valid  = out_valid_q;
    assign out_char   = out_char_q;

    // Decrypt datapath and key-length bookkeeping.
    always_comb begin
        key_legal_s   = (key_char >= 8'h41) && (key_char <= 8'h5A);
        in_letter_s   = (in_char  >= 8'h41) && (in_char  <= 8'h5A);
        key_len_inc_s = key_len_q + ONE_L;
        key_len_new_s = key_legal_s ? key_len_inc_s : key_len_q;
        kidx_wrap_s   = ({1'b0, kidx_q} == (key_len_q - ONE_L));
        k_off_s       = key_mem_q[kidx_q] - 8'h41;
        c_off_s       = in_char - 8'h41;
        if (!in_letter_s) begin
            plain_s = in_char;
        end else if (c_off_s >= k_off_s) begin
            plain_s = in_char - k_off_s;
        end else begin
            plain_s = in_char - k_off_s + 8'd26;
        end
    end

    // Next-state: key FSM, key index and output stage.
    always_comb begin
        state_d     = state_q;
        key_len_d   = key_len_q;
        kidx_d      = kidx_q;
        key_mem_d   = key_mem_q;
        key_err_d   = key_err_q;
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;

        if (key_start) begin
            state_d   = ST_LOAD;
            key_len_d = {LW{1'b0}};
            key_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    if (key_valid) begin
                        if (key_legal_s) begin
                            key_mem_d[key_len_q[KW-1:0]] = key_char;
                        end else begin
                            key_err_d = 1'b1;
                        end
                        key_len_d = key_len_new_s;
                        // Filling the last slot ends the load even without key_last.
                        if (key_legal_s && (key_len_inc_s == MAX_LEN)) begin
                            state_d = ST_RUN;
                            kidx_d  = {KW{1'b0}};
                        end else if (key_last) begin
                            if (key_len_new_s != {LW{1'b0}}) begin
                                state_d = ST_RUN;
                                kidx_d  = {KW{1'b0}};
                            end else begin
                                key_err_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (accept_s && in_letter_s) begin
                        kidx_d = kidx_wrap_s ? {KW{1'b0}} : kidx_q + KW'(1);
                    end else begin
                        kidx_d = kidx_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (resync) begin
            kidx_d = {KW{1'b0}};
        end else begin
            kidx_d = kidx_d;
        end

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_char_d  = plain_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        key_ready_d  = (state_d == ST_LOAD);
        key_loaded_d = (state_d == ST_RUN);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_len_q    <= {LW{1'b0}};
            kidx_q       <= {KW{1'b0}};
            key_err_q    <= 1'b0;
            key_ready_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_char_q   <= 8'h00;
            for (int i = 0; i < MAX_KEY_LEN; i++) begin
                key_mem_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            key_len_q    <= key_len_d;
            kidx_q       <= kidx_d;
            key_err_q    <= key_err_d;
            key_ready_q  <= key_ready_d;
            key_loaded_q <= key_loaded_d;
            out_valid_q  <= out_valid_d;
            out_char_q   <= out_char_d;
            key_mem_q    <= key_mem_d;
        end
    end
endmodule

// File: tb/tb_vigenere_stream_decryptor.sv
// Directed bench for vigenere_stream_decryptor: hand-computed plaintext for each
// ciphertext stream, key-load corner cases, back-pressure and reset behaviour.
module tb_vigenere_stream_decryptor;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_start, key_valid, key_last, key_ready, key_loaded, key_err;
    logic [7:0] key_char;
    logic       resync, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_char, out_char;

    int n_cmp = 0;
    int n_err = 0;

    vigenere_stream_decryptor #(.MAX_KEY_LEN(16)) dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_valid(key_valid), .key_char(key_char),
        .key_last(key_last), .key_ready(key_ready), .key_loaded(key_loaded),
        .key_err(key_err), .resync(resync),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input string k, input string tag);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        check1({tag, " key_ready"}, key_ready, 1'b1);
        for (int i = 0; i < k.len(); i++) begin
            key_valid = 1'b1;
            key_char  = k[i];
            key_last  = (i == k.len() - 1);
            tick();
        end
        key_valid = 1'b0;
        key_last  = 1'b0;
    endtask

    task automatic stream(input string cin, input string exp, input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < cin.len(); i++) begin
            in_valid = 1'b1;
            in_char  = cin[i];
            #1;
            check1({tag, " in_ready"}, in_ready, 1'b1);
            tick();
            check1({tag, " out_valid"}, out_valid, 1'b1);
            check8({tag, " out_char"}, out_char, exp[i]);
        end
        in_valid = 1'b0;
        tick();
        check1({tag, " drained"}, out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; key_start = 1'b0; key_valid = 1'b0; key_char = 8'h00; key_last = 1'b0;
        resync = 1'b0; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        check1("rst key_ready", key_ready, 1'b0);
        check1("rst key_loaded", key_loaded, 1'b0);
        check1("rst key_err", key_err, 1'b0);
        check1("rst out_valid", out_valid, 1'b0);
        check8("rst out_char", out_char, 8'h00);
        check1("rst in_ready", in_ready, 1'b0);
        rst = 1'b0;
        tick();

        // 1: LEMON / ATTACK at one char per cycle
        load_key("LEMON", "t1");
        check1("t1 key_loaded", key_loaded, 1'b1);
        check1("t1 key_ready", key_ready, 1'b0);
        stream("LXFOPV", "ATTACK", "t1");

        // 2: space passes through without consuming a key slot
        load_key("LEMON", "t2");
        stream("LX FO", "AT TA", "t2");

        // 3: wrap below zero and the zero-shift edge
        load_key("B", "t3a");
        stream("A", "Z", "t3a");
        load_key("Z", "t3b");
        stream("Z", "A", "t3b");

        // 4: back-pressure on key "AB": B->B, D->C
        load_key("AB", "t4");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = "B";
        tick();
        in_char = "D";
        for (int i = 0; i < 3; i++) begin
            #1;
            check1("t4 stall in_ready", in_ready, 1'b0);
            check1("t4 stall out_valid", out_valid, 1'b1);
            check8("t4 stall out_char", out_char, "B");
            tick();
        end
        out_ready = 1'b1;
        #1;
        check1("t4 resume in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check1("t4 second out_valid", out_valid, 1'b1);
        check8("t4 second out_char", out_char, "C");
        tick();
        check1("t4 drained", out_valid, 1'b0);

        // 5: resync restarts the key index and beats a same-cycle data beat
        load_key("LEMON", "t5");
        stream("LXF", "ATT", "t5a");
        resync   = 1'b1;
        in_valid = 1'b1;
        in_char  = "L";
        #1;
        check1("t5 resync in_ready", in_ready, 1'b0);
        tick();
        resync   = 1'b0;
        in_valid = 1'b0;
        check1("t5 resync no output", out_valid, 1'b0);
        stream("LXF", "ATT", "t5b");

        // 6a: illegal char dropped, key becomes "AB"
        load_key("A1B", "t6a");
        check1("t6a key_err", key_err, 1'b1);
        check1("t6a key_loaded", key_loaded, 1'b1);
        stream("BD", "BC", "t6a");

        // 6b: key_last with empty key stays in LOAD
        load_key("1", "t6b");
        check1("t6b key_err", key_err, 1'b1);
        check1("t6b key_ready", key_ready, 1'b1);
        check1("t6b key_loaded", key_loaded, 1'b0);

        // 6c: 16 legal chars auto-enter RUN; a 17th offer is ignored
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        check1("t6c key_err cleared", key_err, 1'b0);
        for (int i = 0; i < 16; i++) begin
            key_valid = 1'b1;
            key_char  = 8'h41 + 8'(i);
            tick();
        end
        check1("t6c key_loaded", key_loaded, 1'b1);
        check1("t6c key_ready", key_ready, 1'b0);
        key_char = "Z";
        tick();
        key_valid = 1'b0;
        check1("t6c still run", key_loaded, 1'b1);
        stream("AB", "AA", "t6c");

        // key_start while output pending: pending char still delivered
        load_key("LEMON", "t7");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = "L";
        tick();
        in_valid  = 1'b0;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        check1("t7 pending out_valid", out_valid, 1'b1);
        check8("t7 pending out_char", out_char, "A");
        check1("t7 key_ready", key_ready, 1'b1);
        in_valid  = 1'b1;
        in_char   = "X";
        out_ready = 1'b1;
        #1;
        check1("t7 load in_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0;
        check1("t7 drained", out_valid, 1'b0);

        // reset mid-stream discards the pending output and the key
        load_key("LEMON", "t8");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = "L";
        tick();
        in_valid = 1'b0;
        check1("t8 pending", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("t8 out_valid", out_valid, 1'b0);
        check8("t8 out_char", out_char, 8'h00);
        check1("t8 key_loaded", key_loaded, 1'b0);
        check1("t8 key_ready", key_ready, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
